// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: paces rounds on a tick,
// lights one mole per round and scores presses across three phases.
module mole_round_ctrl #(
  parameter int N_MOLES   = 8,
  parameter int TICK_DIV  = 100000000,
  parameter int SCORE_W   = 8,
  parameter int ROUNDS_P1 = 8,
  parameter int ROUNDS_P2 = 8,
  parameter int ROUNDS_P3 = 8,
  parameter int UP_P1     = 3,
  parameter int UP_P2     = 2,
  parameter int UP_P3     = 1,
  localparam int IDX_W    = $clog2(N_MOLES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_MOLES-1:0] button,
  input  logic [IDX_W-1:0]   number,
  output logic [N_MOLES-1:0] led,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         misses,
  output logic [1:0]         phase,
  output logic               done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    UP,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic               tick;
  logic [N_MOLES-1:0] btn_m, btn_s, btn_p;
  logic               press;
  logic [IDX_W-1:0]   idx_q;
  logic [N_MOLES-1:0] led_c;
  logic [15:0]        up_q;
  logic [15:0]        round_q;
  logic [1:0]         phase_q;
  logic [SCORE_W-1:0] score_q;
  logic [7:0]         miss_q;
  logic [15:0]        rlim, ulim;
  logic               timeout;
  logic               round_end;
  logic               last_in_phase;
  logic               hit;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] score_nx;
  logic [7:0]         miss_nx;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  // counter realigns to 0 whenever the FSM enters a new state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if ((state_d != state_q) || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_m <= '1;
      btn_s <= '1;
      btn_p <= '1;
    end else begin
      btn_m <= button;
      btn_s <= btn_m;
      btn_p <= btn_s;
    end
  end

  assign press = (btn_s != '1) && (btn_p == '1);

  always_comb begin
    led_c = '0;
    for (int i = 0; i < N_MOLES; i++) begin
      if (32'(idx_q) == i) led_c[i] = 1'b1;
    end
    if (32'(idx_q) >= 32'(N_MOLES)) led_c[0] = 1'b1;
  end

  always_comb begin
    case (phase_q)
      2'd2:    begin rlim = 16'(ROUNDS_P2); ulim = 16'(UP_P2); end
      2'd3:    begin rlim = 16'(ROUNDS_P3); ulim = 16'(UP_P3); end
      default: begin rlim = 16'(ROUNDS_P1); ulim = 16'(UP_P1); end
    endcase
  end

  assign hit           = press && (btn_s == ~led_c);
  assign timeout       = tick && (up_q == ulim - 16'd1);
  assign round_end     = (state_q == UP) && (press || timeout);
  assign last_in_phase = (round_q == rlim - 16'd1);

  assign sum      = {1'b0, score_q} + {{(SCORE_W-1){1'b0}}, phase_q};
  assign score_nx = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  assign miss_nx  = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = GAP;
      GAP:        if (tick) state_d = UP;
      UP: begin
        if (round_end) begin
          state_d = (last_in_phase && phase_q == 2'd3) ? DONE : GAP;
        end
      end
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    led    = (state_q == UP) ? led_c : '0;
    done   = (state_q == DONE);
    score  = score_q;
    misses = miss_q;
    phase  = phase_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      up_q    <= '0;
      round_q <= '0;
      phase_q <= '0;
      score_q <= '0;
      miss_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            score_q <= '0;
            miss_q  <= '0;
            round_q <= '0;
            phase_q <= 2'd1;
          end
        end
        GAP: begin
          if (tick) begin
            idx_q <= number;
            up_q  <= '0;
          end
        end
        UP: begin
          if (round_end) begin
            if (hit) begin
              score_q <= score_nx;
            end else begin
              miss_q <= miss_nx;
            end
            if (last_in_phase) begin
              round_q <= '0;
              phase_q <= (phase_q == 2'd3) ? 2'd0 : phase_q + 2'd1;
            end else begin
              round_q <= round_q + 16'd1;
            end
          end else if (tick) begin
            up_q <= up_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
